npu_rd_arb: RTL and testbench

Round-robin arbiter that shares the NPU's single AXI4 read master port (towards the processing-system slave port) between NREQ internal read requesters, such as the weight, activation and descriptor fetch engines. It serialises AR requests onto the master port and tags each one with an ID encoding the requester index. R beats are routed back to the requester by RID, and the total number of outstanding bursts is capped. It sits inside the NPU top, between the fetch engines and the AXI master interface.

---
 rtl/npu_rd_arb_pkg.sv | 8 +
 rtl/npu_rd_arb_if.sv | 45 ++++
 rtl/npu_rr_pick.sv | 19 +
 rtl/npu_rd_arb.sv | 85 ++++++++
 tb/tb_npu_rd_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/npu_rd_arb_pkg.sv
// npu_rd_arb_pkg: shared AXI read-arbiter constants and state type
package npu_rd_arb_pkg;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int NREQ_DEF = 4;
  localparam int MAXOUT_DEF = 4;
  typedef enum logic {IDLE, ISSUE} rd_arb_state_t;
endpackage

// File: rtl/npu_rd_arb_if.sv
// npu_rd_arb_if: requester-side and AXI read-master signals of the read arbiter
interface npu_rd_arb_if #(
  parameter int NREQ = 4,
  parameter int IW = 6,
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [NREQ-1:0] req_arvalid;
  logic [NREQ*AW-1:0] req_araddr;
  logic [NREQ*8-1:0] req_arlen;
  logic [NREQ-1:0] req_arready;
  logic [DW-1:0] req_rdata;
  logic [1:0] req_rresp;
  logic req_rlast;
  logic [NREQ-1:0] req_rvalid;
  logic [NREQ-1:0] req_rready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic [3:0] m_axi_arqos;
  logic m_axi_arvalid;
  logic m_axi_arready;
  logic [IW-1:0] m_axi_rid;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0] m_axi_rresp;
  logic m_axi_rlast;
  logic m_axi_rvalid;
  logic m_axi_rready;
  modport master (
    input req_arvalid, req_araddr, req_arlen, req_rready, m_axi_arready,
          m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output req_arready, req_rdata, req_rresp, req_rlast, req_rvalid,
           m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
           m_axi_arqos, m_axi_arvalid, m_axi_rready
  );
  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_rready, m_axi_arready,
           m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input req_arready, req_rdata, req_rresp, req_rlast, req_rvalid,
          m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
          m_axi_arqos, m_axi_arvalid, m_axi_rready
  );
endinterface

// File: rtl/npu_rr_pick.sv
// npu_rr_pick: rotate-priority encoder, first set request at or above ptr (mod NREQ)
module npu_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [$clog2(NREQ)-1:0] o_gnt,
  output logic                    o_any
);
  logic [2*NREQ-1:0] w_rot;
  assign w_rot = {i_req, i_req} >> i_ptr;
  assign o_any = |i_req;
  // Descending scan so the lowest rotated offset wins.
  always_comb begin
    o_gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (w_rot[k]) o_gnt = $clog2(NREQ)'((int'(i_ptr) + k) % NREQ);
  end
endmodule

// File: rtl/npu_rd_arb.sv
// npu_rd_arb: round-robin AXI4 read arbiter with RID routing and outstanding cap.
// Define NPU_RD_ARB_QOS_EN to give requester 0 absolute priority with arqos 4'hF.
module npu_rd_arb
  import npu_rd_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW = 6,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAXOUT = MAXOUT_DEF
) (
  input  logic          m_axi_aclk,
  input  logic          m_axi_arst,
  npu_rd_arb_if.master  bus,
  output logic          err
);
  localparam int PW = $clog2(NREQ);
  rd_arb_state_t r_state, w_next;
  logic [PW-1:0] r_gnt, r_ptr, w_pick, w_gnt, w_rid;
  logic [AW-1:0] r_addr;
  logic [7:0] r_len;
  logic [3:0] r_cnt, r_qos, w_qos;
  logic r_first, r_err, w_any, w_start, w_inc, w_dec, w_under, w_rid_ok, w_adv;
  npu_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req(bus.req_arvalid), .i_ptr(r_ptr), .o_gnt(w_pick), .o_any(w_any)
  );
`ifdef NPU_RD_ARB_QOS_EN
  assign w_gnt = bus.req_arvalid[0] ? '0 : w_pick;
  assign w_qos = (w_gnt == '0) ? 4'hF : 4'h0;
  assign w_adv = r_gnt != '0;
`else
  assign w_gnt = w_pick;
  assign w_qos = 4'h0;
  assign w_adv = 1'b1;
`endif
  assign w_start = r_state == IDLE && w_any && r_cnt < 4'(MAXOUT);
  assign w_inc = bus.m_axi_arvalid && bus.m_axi_arready;
  assign w_rid_ok = bus.m_axi_rid < IW'(NREQ);
  assign w_rid = bus.m_axi_rid[PW-1:0];
  assign w_dec = bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;
  assign w_under = w_dec && r_cnt == '0;
  always_ff @(posedge m_axi_aclk)
    r_state <= m_axi_arst ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_start ? ISSUE : IDLE) : (bus.m_axi_arready ? IDLE : ISSUE);
  // Unknown RIDs are accepted and dropped so the PS port never stalls.
  always_comb begin
    bus.m_axi_arvalid = r_state == ISSUE;
    bus.req_arready = (r_state == ISSUE && r_first) ? NREQ'(1) << r_gnt : '0;
    bus.req_rvalid = (bus.m_axi_rvalid && w_rid_ok) ? NREQ'(1) << w_rid : '0;
    bus.m_axi_rready = w_rid_ok ? bus.req_rready[w_rid] : 1'b1;
  end
  always_ff @(posedge m_axi_aclk)
    if (m_axi_arst) begin
      r_gnt <= '0;
      r_ptr <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_qos <= '0;
      r_first <= 1'b0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_first <= w_start;
      if (w_start) begin
        r_gnt <= w_gnt;
        r_addr <= bus.req_araddr[w_gnt*AW +: AW];
        r_len <= bus.req_arlen[w_gnt*8 +: 8];
        r_qos <= w_qos;
      end
      if (w_inc && w_adv) r_ptr <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
      r_cnt <= r_cnt + 4'(w_inc) - 4'(w_dec && !w_under);
      r_err <= r_err || (bus.m_axi_rvalid && !w_rid_ok) || w_under;
    end
  assign bus.m_axi_arid = IW'(r_gnt);
  assign bus.m_axi_araddr = r_addr;
  assign bus.m_axi_arlen = r_len;
  assign bus.m_axi_arsize = 3'($clog2(DW / 8));
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arqos = r_qos;
  assign bus.req_rdata = bus.m_axi_rdata;
  assign bus.req_rresp = bus.m_axi_rresp;
  assign bus.req_rlast = bus.m_axi_rlast;
  assign err = r_err;
endmodule

// File: tb/tb_npu_rd_arb.sv
// tb_npu_rd_arb: directed self-checking bench for npu_rd_arb (NREQ=4, MAXOUT=4)
module tb_npu_rd_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int pass_n = 0;
  int tot_n = 0;
  int hs;
  npu_rd_arb_if #(.NREQ(4), .IW(6), .AW(32), .DW(32)) bus ();
  npu_rd_arb #(.NREQ(4), .IW(6), .AW(32), .DW(32), .MAXOUT(4)) dut (
    .m_axi_aclk(clk), .m_axi_arst(rst), .bus(bus), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_n++;
    assert (obs === exp) pass_n++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic beat(input int id, input logic last);
    bus.m_axi_rvalid = 1'b1;
    bus.m_axi_rid = 6'(id);
    bus.m_axi_rlast = last;
  endtask
  initial begin
    bus.req_arvalid = '0;
    bus.req_araddr = '0;
    bus.req_arlen = '0;
    bus.req_rready = '0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rid = '0;
    bus.m_axi_rdata = '0;
    bus.m_axi_rresp = '0;
    bus.m_axi_rlast = 1'b0;
    bus.m_axi_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req_araddr[i*32 +: 32] = 32'h2000_0000 + 32'(i) * 32'h100;
      bus.req_arlen[i*8 +: 8] = 8'(i + 1);
    end
    tick;
    tick;
    chk("rst_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
    chk("rst_req_arready", 64'(bus.req_arready), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_arid", 64'(bus.m_axi_arid), 64'h0);
    chk("rst_araddr", 64'(bus.m_axi_araddr), 64'h0);
    chk("rst_arlen", 64'(bus.m_axi_arlen), 64'h0);
    chk("rst_arqos", 64'(bus.m_axi_arqos), 64'h0);
    chk("rst_req_rvalid", 64'(bus.req_rvalid), 64'h0);
    rst = 1'b0;
    bus.m_axi_arready = 1'b1;
    bus.req_rready = 4'hF;
`ifdef NPU_RD_ARB_QOS_EN
    bus.req_arvalid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("qos_arvalid", 64'(bus.m_axi_arvalid), 64'h1);
      chk("qos_arid", 64'(bus.m_axi_arid), 64'h0);
      chk("qos_arqos", 64'(bus.m_axi_arqos), 64'hF);
      tick;
      chk("qos_gap", 64'(bus.m_axi_arvalid), 64'h0);
      if (k == 2) bus.req_arvalid = 4'b0010;
    end
    tick;
    chk("qos_r1_arid", 64'(bus.m_axi_arid), 64'h1);
    chk("qos_r1_arqos", 64'(bus.m_axi_arqos), 64'h0);
    bus.req_arvalid = '0;
    tick;
    for (int k = 0; k < 4; k++) begin
      beat(0, 1'b1);
      tick;
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast = 1'b0;
`else
    bus.req_arvalid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick;
      bus.m_axi_rvalid = 1'b0;
      bus.m_axi_rlast = 1'b0;
      chk("rr_arvalid", 64'(bus.m_axi_arvalid), 64'h1);
      chk("rr_arid", 64'(bus.m_axi_arid), 64'(k % 4));
      chk("rr_req_arready", 64'(bus.req_arready), 64'(1) << (k % 4));
      chk("rr_araddr", 64'(bus.m_axi_araddr), 64'h2000_0000 + 64'(k % 4) * 64'h100);
      chk("rr_arlen", 64'(bus.m_axi_arlen), 64'(k % 4 + 1));
      chk("rr_arqos", 64'(bus.m_axi_arqos), 64'h0);
      tick;
      chk("rr_gap_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
      chk("rr_gap_req_arready", 64'(bus.req_arready), 64'h0);
      beat(k % 4, 1'b1);
      bus.m_axi_rdata = 32'hA000 + 32'(k);
      #1;
      chk("rr_req_rvalid", 64'(bus.req_rvalid), 64'(1) << (k % 4));
      chk("rr_rdata", 64'(bus.req_rdata), 64'hA000 + 64'(k));
      chk("rr_rready", 64'(bus.m_axi_rready), 64'h1);
      if (k == 4) bus.req_arvalid = '0;
    end
    tick;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast = 1'b0;
    chk("rr_err", 64'(err), 64'h0);
`endif
    bus.req_araddr[64 +: 32] = 32'h1000_0040;
    bus.req_arlen[16 +: 8] = 8'd15;
    bus.req_arvalid = 4'b0100;
    tick;
    chk("r2_arvalid", 64'(bus.m_axi_arvalid), 64'h1);
    chk("r2_araddr", 64'(bus.m_axi_araddr), 64'h1000_0040);
    chk("r2_arlen", 64'(bus.m_axi_arlen), 64'd15);
    chk("r2_arsize", 64'(bus.m_axi_arsize), 64'd2);
    chk("r2_arburst", 64'(bus.m_axi_arburst), 64'd1);
    chk("r2_arid", 64'(bus.m_axi_arid), 64'd2);
    chk("r2_req_arready", 64'(bus.req_arready), 64'h4);
    bus.req_arvalid = '0;
    tick;
    bus.req_rready = 4'b0100;
    for (int b = 0; b < 16; b++) begin
      beat(2, b == 15);
      bus.m_axi_rdata = 32'hD000_0000 + 32'(b);
      #1;
      chk("r2_req_rvalid", 64'(bus.req_rvalid), 64'h4);
      chk("r2_rdata", 64'(bus.req_rdata), 64'hD000_0000 + 64'(b));
      tick;
    end
    beat(2, 1'b0);
    bus.req_rready = 4'b1011;
    #1;
    chk("r2_backpressure", 64'(bus.m_axi_rready), 64'h0);
    bus.m_axi_rvalid = 1'b0;
    bus.req_rready = 4'hF;
    bus.req_arvalid = 4'hF;
    hs = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (bus.m_axi_arvalid && bus.m_axi_arready) hs++;
    end
    chk("max_handshakes", 64'(hs), 64'd4);
    beat(0, 1'b1);
    tick;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast = 1'b0;
    tick;
    chk("max_fifth_ar", 64'(bus.m_axi_arvalid), 64'h1);
    bus.req_arvalid = '0;
    tick;
    for (int k = 0; k < 4; k++) begin
      beat(0, 1'b1);
      tick;
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast = 1'b0;
    chk("max_err", 64'(err), 64'h0);
    bus.req_rready = '0;
    beat(5, 1'b0);
    #1;
    chk("bad_rid_rready", 64'(bus.m_axi_rready), 64'h1);
    chk("bad_rid_req_rvalid", 64'(bus.req_rvalid), 64'h0);
    tick;
    bus.m_axi_rvalid = 1'b0;
    chk("bad_rid_err", 64'(err), 64'h1);
    tick;
    tick;
    chk("bad_rid_err_held", 64'(err), 64'h1);
    rst = 1'b1;
    tick;
    chk("err_cleared", 64'(err), 64'h0);
    rst = 1'b0;
    bus.req_rready = 4'hF;
    beat(1, 1'b1);
    #1;
    chk("under_req_rvalid", 64'(bus.req_rvalid), 64'h2);
    tick;
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast = 1'b0;
    chk("under_err", 64'(err), 64'h1);
    bus.req_arvalid = 4'hF;
    hs = 0;
    for (int c = 0; c < 12; c++) begin
      tick;
      if (bus.m_axi_arvalid && bus.m_axi_arready) hs++;
    end
    chk("under_count_zero", 64'(hs), 64'd4);
    bus.req_arvalid = '0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.req_arvalid = 4'b0010;
    tick;
    chk("hold_arvalid", 64'(bus.m_axi_arvalid), 64'h1);
    chk("hold_req_arready", 64'(bus.req_arready), 64'h2);
    chk("hold_arid", 64'(bus.m_axi_arid), 64'h1);
    bus.req_arvalid = '0;
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("hold_arvalid_c", 64'(bus.m_axi_arvalid), 64'h1);
      chk("hold_araddr_c", 64'(bus.m_axi_araddr), 64'h2000_0100);
      chk("hold_arid_c", 64'(bus.m_axi_arid), 64'h1);
      chk("hold_pulse_c", 64'(bus.req_arready), 64'h0);
    end
    rst = 1'b1;
    tick;
    chk("midrst_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
    chk("midrst_araddr", 64'(bus.m_axi_araddr), 64'h0);
    chk("midrst_arid", 64'(bus.m_axi_arid), 64'h0);
    rst = 1'b0;
    tick;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
